// File: rtl/river_cfg_pkg.sv
// Core-wide configuration constants shared by the River pipeline blocks.
package river_cfg_pkg;
  localparam int RISCV_ARCH        = 64;
  localparam int CFG_REG_TAG_WIDTH = 3;
endpackage

// File: rtl/wb_arbiter_pkg.sv
// Types, FSM encodings and register reset image for the writeback arbiter.
package wb_arbiter_pkg;
  import river_cfg_pkg::*;

  localparam logic [0:0] State_ExecPrio    = 1'b0;
  localparam logic [0:0] State_DrainForced = 1'b1;

  localparam int STARVE_W = 8;

  typedef struct packed {
    logic [5:0]                   waddr;
    logic [RISCV_ARCH-1:0]        wdata;
    logic [CFG_REG_TAG_WIDTH-1:0] wtag;
  } WbEntry;

  typedef struct packed {
    logic [0:0]          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic                wena;
    WbEntry              w;
  } WbArbiter_registers;

  localparam WbArbiter_registers WbArbiter_r_reset = '{
    state:      State_ExecPrio,
    starve_cnt: '0,
    wena:       1'b0,
    w:          '0
  };

  // x0 is hardwired zero, so writes to it are swallowed at the ports.
  function automatic logic nz_addr(input logic [5:0] a);
    return a != 6'd0;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: execute/memaccess requests in, register-file write out.
// WB_ARBITER_PENDING_CHECK_EN adds the i_raddr / o_rpending lookup pair.
interface wb_arbiter_if;
  import river_cfg_pkg::*;

  logic                         i_e_wena;
  logic [5:0]                   i_e_waddr;
  logic [RISCV_ARCH-1:0]        i_e_wdata;
  logic [CFG_REG_TAG_WIDTH-1:0] i_e_wtag;
  logic                         o_e_wready;
  logic                         i_m_wena;
  logic [5:0]                   i_m_waddr;
  logic [RISCV_ARCH-1:0]        i_m_wdata;
  logic [CFG_REG_TAG_WIDTH-1:0] i_m_wtag;
  logic                         o_m_wready;
  logic                         o_wena;
  logic [5:0]                   o_waddr;
  logic [RISCV_ARCH-1:0]        o_wdata;
  logic [CFG_REG_TAG_WIDTH-1:0] o_wtag;
  logic                         o_fifo_empty;
`ifdef WB_ARBITER_PENDING_CHECK_EN
  logic [5:0]                   i_raddr;
  logic                         o_rpending;
`endif

  modport slave (
    input  i_e_wena, i_e_waddr, i_e_wdata, i_e_wtag,
    input  i_m_wena, i_m_waddr, i_m_wdata, i_m_wtag,
    output o_e_wready, o_m_wready,
    output o_wena, o_waddr, o_wdata, o_wtag, o_fifo_empty
`ifdef WB_ARBITER_PENDING_CHECK_EN
    , input i_raddr, output o_rpending
`endif
  );

  modport master (
    output i_e_wena, i_e_waddr, i_e_wdata, i_e_wtag,
    output i_m_wena, i_m_waddr, i_m_wdata, i_m_wtag,
    input  o_e_wready, o_m_wready,
    input  o_wena, o_waddr, o_wdata, o_wtag, o_fifo_empty
`ifdef WB_ARBITER_PENDING_CHECK_EN
    , output i_raddr, input o_rpending
`endif
  );
endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of writeback entries with head/tail pointers and occupancy count.
// WB_ARBITER_PENDING_CHECK_EN adds an address match across all valid entries.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  WbEntry           i_din,
  input  logic             i_pop,
  output WbEntry           o_head,
  output logic [CNT_W-1:0] o_count
`ifdef WB_ARBITER_PENDING_CHECK_EN
  , input  logic [5:0]     i_raddr
  , output logic           o_match
`endif
);
  WbEntry             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign do_push = i_push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = i_pop  && (count_q != '0);
  assign o_head  = mem_q[head_q];
  assign o_count = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = do_pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = do_push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[tail_q] <= i_din;
  end

`ifdef WB_ARBITER_PENDING_CHECK_EN
  // Entry i is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    off     = '0;
    o_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if (({1'b0, off} < count_q) && (mem_q[i].waddr == i_raddr)) o_match = 1'b1;
    end
    if (i_raddr == 6'd0) o_match = 1'b0;
  end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: execute has priority on the register-file port, memaccess
// results are buffered and force-drained after STARVE_LIMIT lost cycles.
// Optional WB_ARBITER_PENDING_CHECK_EN exposes a pending-load lookup.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         i_clk,
  input logic         i_nrst,
  wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  WbArbiter_registers r_q, r_d;
  WbEntry             din, head;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty, m_rdy, e_rdy, push, pop;

  assign fifo_empty = (count == '0);
  assign m_rdy      = (count != CNT_W'(DEPTH));
  assign push       = bus.i_m_wena && m_rdy && nz_addr(bus.i_m_waddr);
  assign din        = '{waddr: bus.i_m_waddr, wdata: bus.i_m_wdata, wtag: bus.i_m_wtag};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_push  (push),
    .i_din   (din),
    .i_pop   (pop),
    .o_head  (head),
    .o_count (count)
`ifdef WB_ARBITER_PENDING_CHECK_EN
    , .i_raddr (bus.i_raddr)
    , .o_match (bus.o_rpending)
`endif
  );

  always_comb begin
    r_d      = r_q;
    r_d.wena = 1'b0;
    e_rdy    = 1'b1;
    pop      = 1'b0;
    case (r_q.state)
      State_DrainForced: begin
        // One forced entry per starvation event, then execute regains priority.
        e_rdy          = 1'b0;
        pop            = !fifo_empty;
        r_d.starve_cnt = '0;
        r_d.state      = State_ExecPrio;
      end
      default: begin
        if (bus.i_e_wena) begin
          if (fifo_empty) begin
            r_d.starve_cnt = '0;
          end else begin
            r_d.starve_cnt = r_q.starve_cnt + STARVE_W'(1);
            if (r_d.starve_cnt >= STARVE_W'(STARVE_LIMIT)) r_d.state = State_DrainForced;
          end
          if (nz_addr(bus.i_e_waddr)) begin
            r_d.wena = 1'b1;
            r_d.w    = '{waddr: bus.i_e_waddr, wdata: bus.i_e_wdata, wtag: bus.i_e_wtag};
          end
        end else begin
          r_d.starve_cnt = '0;
          pop            = !fifo_empty;
        end
      end
    endcase
    if (pop) begin
      r_d.wena = 1'b1;
      r_d.w    = head;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_q <= WbArbiter_r_reset;
    else         r_q <= r_d;
  end

  assign bus.o_e_wready   = e_rdy;
  assign bus.o_m_wready   = m_rdy;
  assign bus.o_wena       = r_q.wena;
  assign bus.o_waddr      = r_q.w.waddr;
  assign bus.o_wdata      = r_q.w.wdata;
  assign bus.o_wtag       = r_q.w.wtag;
  assign bus.o_fifo_empty = fifo_empty;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4) with hand-computed expectations.
module tb_wb_arbiter;
  import river_cfg_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e_drv(input logic en, input logic [5:0] a, input logic [RISCV_ARCH-1:0] d,
                       input logic [CFG_REG_TAG_WIDTH-1:0] t);
    bus.i_e_wena = en; bus.i_e_waddr = a; bus.i_e_wdata = d; bus.i_e_wtag = t;
  endtask

  task automatic m_drv(input logic en, input logic [5:0] a, input logic [RISCV_ARCH-1:0] d,
                       input logic [CFG_REG_TAG_WIDTH-1:0] t);
    bus.i_m_wena = en; bus.i_m_waddr = a; bus.i_m_wdata = d; bus.i_m_wtag = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    e_drv(0, 0, 0, 0);
    m_drv(0, 0, 0, 0);
`ifdef WB_ARBITER_PENDING_CHECK_EN
    bus.i_raddr = 6'd0;
`endif
    #2;
    chk("rst_wena",  bus.o_wena,       0);
    chk("rst_waddr", bus.o_waddr,      0);
    chk("rst_empty", bus.o_fifo_empty, 1);
    chk("rst_mrdy",  bus.o_m_wready,   1);
    chk("rst_erdy",  bus.o_e_wready,   1);
    tick();
    nrst = 1'b1;
    tick();

    // memaccess alone: accepted at edge 0, dequeued at edge 1, visible after
    m_drv(1, 5, 64'h1122334455667788, 3);
    #1;
    chk("ma_mrdy", bus.o_m_wready, 1);
    tick();
    m_drv(0, 0, 0, 0);
    #1;
    chk("ma_wena_early", bus.o_wena,       0);
    chk("ma_queued",     bus.o_fifo_empty, 0);
    chk("ma_erdy",       bus.o_e_wready,   1);
    tick();
    chk("ma_wena",  bus.o_wena,       1);
    chk("ma_waddr", bus.o_waddr,      5);
    chk("ma_wdata", bus.o_wdata,      64'h1122334455667788);
    chk("ma_wtag",  bus.o_wtag,       3);
    chk("ma_empty", bus.o_fifo_empty, 1);
    tick();
    chk("ma_idle", bus.o_wena, 0);

    // fill while execute writes, third request held until space frees up
    e_drv(1, 7, 64'hAA, 1);
    m_drv(1, 8, 64'h100, 2);
    tick();
    chk("fill_e_wena",  bus.o_wena,  1);
    chk("fill_e_waddr", bus.o_waddr, 7);
    chk("fill_e_wdata", bus.o_wdata, 64'hAA);
    m_drv(1, 9, 64'h200, 2);
    #1;
    chk("fill_mrdy1", bus.o_m_wready, 1);
    tick();
    m_drv(1, 11, 64'h300, 4);
    e_drv(0, 0, 0, 0);
    #1;
    chk("fill_full", bus.o_m_wready, 0);
    tick();
    chk("fill_d0_addr", bus.o_waddr, 8);
    chk("fill_d0_data", bus.o_wdata, 64'h100);
    chk("fill_d0_tag",  bus.o_wtag,  2);
    chk("fill_mrdy2",   bus.o_m_wready, 1);
    tick();
    m_drv(0, 0, 0, 0);
    chk("fill_d1_addr", bus.o_waddr, 9);
    chk("fill_d1_data", bus.o_wdata, 64'h200);
    tick();
    chk("fill_d2_wena", bus.o_wena,  1);
    chk("fill_d2_addr", bus.o_waddr, 11);
    chk("fill_d2_data", bus.o_wdata, 64'h300);
    chk("fill_d2_tag",  bus.o_wtag,  4);
    tick();
    chk("fill_done_wena",  bus.o_wena,       0);
    chk("fill_done_empty", bus.o_fifo_empty, 1);

    // starvation: one queued entry, execute every cycle, forced drain in cycle 5
    e_drv(1, 3, 64'h33, 5);
    m_drv(1, 20, 64'h2020, 6);
    tick();
    m_drv(0, 0, 0, 0);
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("st_erdy_c%0d", k), bus.o_e_wready, 1);
      tick();
    end
    chk("st_drain_erdy", bus.o_e_wready, 0);
    chk("st_exec_addr",  bus.o_waddr,    3);
    tick();
    chk("st_fwd_wena",  bus.o_wena,       1);
    chk("st_fwd_addr",  bus.o_waddr,      20);
    chk("st_fwd_data",  bus.o_wdata,      64'h2020);
    chk("st_fwd_tag",   bus.o_wtag,       6);
    chk("st_fwd_empty", bus.o_fifo_empty, 1);
    chk("st_resume",    bus.o_e_wready,   1);
    tick();
    chk("st_exec_back", bus.o_waddr, 3);
    chk("st_exec_wena", bus.o_wena,  1);
    e_drv(0, 0, 0, 0);
    tick();
    chk("st_idle", bus.o_wena, 0);

    // x0 writes are acknowledged but never written
    e_drv(1, 0, 64'hDEAD, 1);
    m_drv(1, 0, 64'hBEEF, 2);
    #1;
    chk("x0_erdy", bus.o_e_wready, 1);
    chk("x0_mrdy", bus.o_m_wready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("x0_wena",  bus.o_wena,       0);
      chk("x0_empty", bus.o_fifo_empty, 1);
    end
    e_drv(0, 0, 0, 0);
    m_drv(0, 0, 0, 0);
    tick();
    chk("x0_after", bus.o_wena, 0);

`ifdef WB_ARBITER_PENDING_CHECK_EN
    e_drv(1, 2, 64'h22, 1);
    m_drv(1, 10, 64'hA0, 2);
    tick();
    m_drv(0, 0, 0, 0);
    bus.i_raddr = 6'd10;
    #1;
    chk("pend_hit", bus.o_rpending, 1);
    bus.i_raddr = 6'd11;
    #1;
    chk("pend_other", bus.o_rpending, 0);
    bus.i_raddr = 6'd0;
    #1;
    chk("pend_x0", bus.o_rpending, 0);
    e_drv(0, 0, 0, 0);
    bus.i_raddr = 6'd10;
    tick();
    chk("pend_drain_addr", bus.o_waddr,    10);
    chk("pend_drained",    bus.o_rpending, 0);
    tick();
`endif

    // reset with two entries queued must discard them
    e_drv(1, 1, 64'h11, 1);
    m_drv(1, 12, 64'hC0, 2);
    tick();
    m_drv(1, 13, 64'hD0, 2);
    tick();
    chk("mid_full", bus.o_m_wready, 0);
    e_drv(0, 0, 0, 0);
    m_drv(0, 0, 0, 0);
    nrst = 1'b0;
    #1;
    chk("mid_wena",  bus.o_wena,       0);
    chk("mid_empty", bus.o_fifo_empty, 1);
    chk("mid_mrdy",  bus.o_m_wready,   1);
    tick();
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_nostale", bus.o_wena, 0);
    end
    chk("mid_empty_after", bus.o_fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
